// File: rtl/timer_arbiter_pkg.sv
// Types and helpers shared by the timer arbiter and its bench.
// No ports; provides the FSM state type and a modulo-N increment.
`include "timer_arbiter_defs.svh"

package timer_arbiter_pkg;

    typedef enum logic {
        IDLE = `ST_IDLE,
        RUN  = `ST_RUN
    } state_t;

    // Next round-robin position after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bus of the timer arbiter.
// i_req/i_delay come from the requesters; o_grant/o_done/o_busy/o_count
// go back to them. slave = arbiter side, master = requester side.
interface timer_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [NUM_REQ-1:0]           i_req;
    logic [NUM_REQ*CNT_WIDTH-1:0] i_delay;
    logic [NUM_REQ-1:0]           o_grant;
    logic [NUM_REQ-1:0]           o_done;
    logic                         o_busy;
    logic [CNT_WIDTH-1:0]         o_count;

    modport slave  (input  i_req, i_delay, output o_grant, o_done, o_busy, o_count);
    modport master (output i_req, i_delay, input  o_grant, o_done, o_busy, o_count);
endinterface

// File: rtl/counter_en.sv
// Up-counter with synchronous clear and count enable.
// Ports: i_clk, i_reset (async, active-high), i_clear (sync, wins over
// enable), i_enable, o_count (registered value).
module counter_en #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_enable) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_arbiter_defs.svh
// Shared state encodings for the timer arbiter FSM.
`ifndef TIMER_ARBITER_DEFS_SVH
`define TIMER_ARBITER_DEFS_SVH

`define ST_IDLE 1'b0
`define ST_RUN  1'b1

`endif

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one delay counter between NUM_REQ requesters.
// Ports: i_clk, i_reset (async, active-high), bus (slave side):
//   i_req level requests, i_delay packed per-requester delays,
//   o_grant one-hot grant, o_done one-cycle completion pulse,
//   o_busy high while running, o_count current timer value.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    timer_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t               state_q,  state_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [IDX_W-1:0]     ptr_q,    ptr_d;
    logic [CNT_WIDTH-1:0] dlast_q,  dlast_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [NUM_REQ-1:0]   done_q,   done_d;
    logic                 busy_q,   busy_d;

    logic [CNT_WIDTH-1:0] count;
    logic                 cnt_clear_c;
    logic                 cnt_enable_c;
    logic                 win_valid_c;
    logic [IDX_W-1:0]     win_c;
    logic [CNT_WIDTH-1:0] delay_sel_c;

    counter_en #(.WIDTH(CNT_WIDTH)) u_counter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (cnt_clear_c),
        .i_enable (cnt_enable_c),
        .o_count  (count)
    );

    // First active request at or above the pointer, wrapping.
    always_comb begin : arb_search
        int unsigned idx;
        win_valid_c = 1'b0;
        win_c       = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_valid_c && bus.i_req[IDX_W'(idx)]) begin
                win_valid_c = 1'b1;
                win_c       = IDX_W'(idx);
            end
        end
    end

    // Delay of the candidate winner; constant slices keep the mux simple.
    always_comb begin
        delay_sel_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_c == IDX_W'(k)) begin
                delay_sel_c = bus.i_delay[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    // Next state and registered-output values.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        ptr_d        = ptr_q;
        dlast_d      = dlast_q;
        grant_d      = '0;
        done_d       = '0;
        busy_d       = 1'b0;
        cnt_clear_c  = 1'b1;
        cnt_enable_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    winner_d = win_c;
                    // Zero delay runs as one cycle; terminal compare is D-1.
                    dlast_d  = (delay_sel_c == '0) ? '0 : (delay_sel_c - CNT_WIDTH'(1));
                    grant_d  = NUM_REQ'(1) << win_c;
                    busy_d   = 1'b1;
                    ptr_d    = IDX_W'(wrap_inc(32'(win_c), NUM_REQ));
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!bus.i_req[winner_q]) begin
                    // Withdrawn: drop silently, pointer already advanced.
                    state_d = IDLE;
                end else if (count == dlast_q) begin
                    done_d[winner_q] = 1'b1;
                    state_d          = IDLE;
                end else begin
                    grant_d      = grant_q;
                    busy_d       = 1'b1;
                    cnt_clear_c  = 1'b0;
                    cnt_enable_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            winner_q <= '0;
            ptr_q    <= '0;
            dlast_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            dlast_q  <= dlast_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_count = count;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (4 requesters, 8-bit counter).
module tb_timer_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    timer_arbiter_if #(.NUM_REQ(4), .CNT_WIDTH(8)) bus ();

    timer_arbiter #(.NUM_REQ(4), .CNT_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_g;
    logic [3:0] fair_seq [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] d,
                              input logic b, input logic [7:0] c);
        check({tag, "_grant"}, 32'(bus.o_grant), 32'(g));
        check({tag, "_done"},  32'(bus.o_done),  32'(d));
        check({tag, "_busy"},  32'(bus.o_busy),  32'(b));
        check({tag, "_count"}, 32'(bus.o_count), 32'(c));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.i_req   = 4'b0000;
        bus.i_delay = 32'h0;
        @(negedge clk);
        check_outs("reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
        rst = 1'b0;

        // Single request, D=5: five grant cycles counting 0..4, then done.
        bus.i_delay = {8'd0, 8'd0, 8'd0, 8'd5};
        bus.i_req   = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs($sformatf("single_c%0d", i), 4'b0001, 4'b0000, 1'b1, 8'(i));
        end
        step();
        check_outs("single_done", 4'b0000, 4'b0001, 1'b0, 8'd0);
        bus.i_req = 4'b0000;
        step();
        check_outs("single_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // Round-robin from a fresh pointer, D=2 each, drop req on done.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_delay = {8'd2, 8'd2, 8'd2, 8'd2};
        bus.i_req   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            step();
            check_outs($sformatf("rr%0d_c0", k), exp_g, 4'b0000, 1'b1, 8'd0);
            step();
            check_outs($sformatf("rr%0d_c1", k), exp_g, 4'b0000, 1'b1, 8'd1);
            step();
            check_outs($sformatf("rr%0d_done", k), 4'b0000, exp_g, 1'b0, 8'd0);
            bus.i_req[k] = 1'b0;
        end

        // Fairness: req0 and req2 held, D=3, grants alternate 0,2,0,2.
        fair_seq[0] = 4'b0001;
        fair_seq[1] = 4'b0100;
        fair_seq[2] = 4'b0001;
        fair_seq[3] = 4'b0100;
        bus.i_delay = {8'd0, 8'd3, 8'd0, 8'd3};
        bus.i_req   = 4'b0101;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                check_outs($sformatf("fair%0d_c%0d", g, c), fair_seq[g], 4'b0000, 1'b1, 8'(c));
            end
            step();
            check_outs($sformatf("fair%0d_done", g), 4'b0000, fair_seq[g], 1'b0, 8'd0);
        end
        bus.i_req = 4'b0000;

        // Zero delay on req1: single grant cycle, done next cycle.
        bus.i_delay = 32'h0;
        bus.i_req   = 4'b0010;
        step();
        check_outs("zero_grant", 4'b0010, 4'b0000, 1'b1, 8'd0);
        step();
        check_outs("zero_done", 4'b0000, 4'b0010, 1'b0, 8'd0);
        bus.i_req = 4'b0000;

        // Withdrawal: req3 (D=10) drops after 4 cycles; req0 (D=2) then served.
        bus.i_delay = {8'd10, 8'd0, 8'd0, 8'd2};
        bus.i_req   = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            check_outs($sformatf("wd_c%0d", i), 4'b1000, 4'b0000, 1'b1, 8'(i));
        end
        bus.i_req = 4'b0001;
        step();
        check_outs("wd_abort", 4'b0000, 4'b0000, 1'b0, 8'd0);
        step();
        check_outs("wd_next_c0", 4'b0001, 4'b0000, 1'b1, 8'd0);
        step();
        check_outs("wd_next_c1", 4'b0001, 4'b0000, 1'b1, 8'd1);
        step();
        check_outs("wd_next_done", 4'b0000, 4'b0001, 1'b0, 8'd0);
        bus.i_req = 4'b0000;

        // Reset mid-run at count 6, then req0 beats req1 on restart.
        bus.i_delay = {8'd0, 8'd0, 8'd10, 8'd0};
        bus.i_req   = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            step();
            check_outs($sformatf("rst_run_c%0d", i), 4'b0010, 4'b0000, 1'b1, 8'(i));
        end
        bus.i_req = 4'b0011;
        rst = 1'b1;
        #1;
        check_outs("rst_async", 4'b0000, 4'b0000, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs($sformatf("rst_hold%0d", i), 4'b0000, 4'b0000, 1'b0, 8'd0);
        end
        rst = 1'b0;
        step();
        check_outs("rst_win", 4'b0001, 4'b0000, 1'b1, 8'd0);
        bus.i_req = 4'b0001;
        step();
        check_outs("rst_win_done", 4'b0000, 4'b0001, 1'b0, 8'd0);
        bus.i_req = 4'b0000;
        step();
        check_outs("final_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
